// File: rtl/regb_fifo.sv
// Register-based circular-buffer FIFO with first-word-fall-through read port.
// Storage is an array of reset-to-zero register cells; depth need not be a power of two.

module regb_fifo_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module regb_fifo #(
  parameter int WIDTH = 8,
  parameter int N     = 5
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] wdata,
  input  logic             shift_out,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);

  logic [PW-1:0]            wptr, rptr;
  logic [CW-1:0]            cnt;
  logic [N-1:0][WIDTH-1:0]  mem;
  logic                     push, pop;

  // A push into a full FIFO is only legal when the head is leaving on the same edge.
  assign push = shift_in && (!full || shift_out);
  assign pop  = shift_out && !empty;

  assign full  = (cnt == CNT_FULL);
  assign empty = (cnt == '0);
  assign rdata = mem[rptr];

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_cell
      regb_fifo_cell #(.WIDTH(WIDTH)) u_cell (
        .clk   (clk),
        .res_n (res_n),
        .we    (push && (wptr == PW'(g))),
        .d     (wdata),
        .q     (mem[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= (wptr == LAST) ? '0 : wptr + PW'(1);
      if (pop)  rptr <= (rptr == LAST) ? '0 : rptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_regb_fifo.sv
// Directed plus randomized bench for regb_fifo, checked against a queue model.

module tb_regb_fifo;
  localparam int WIDTH = 8;
  localparam int N     = 5;

  logic             clk = 1'b0;
  logic             res_n;
  logic             shift_in, shift_out;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             full, empty;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q[$];

  regb_fifo #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .shift_in  (shift_in),
    .wdata     (wdata),
    .shift_out (shift_out),
    .rdata     (rdata),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(q.size() == N));
    if (q.size() > 0) chk({tag, ".rdata"}, 32'(rdata), 32'(q[0]));
  endtask

  // Drive one cycle: inputs applied away from the edge, model updated from the
  // acceptance rules, outputs sampled 1 unit after the rising edge.
  task automatic step(input logic si, input logic so, input logic [WIDTH-1:0] wd, input string tag);
    bit push_ok, pop_ok;
    shift_in  = si;
    shift_out = so;
    wdata     = wd;
    push_ok = si && (q.size() < N || so);
    pop_ok  = so && (q.size() > 0);
    @(posedge clk);
    if (pop_ok)  void'(q.pop_front());
    if (push_ok) q.push_back(wd);
    #1;
    check_model(tag);
  endtask

  initial begin
    res_n = 1'b1; shift_in = 1'b0; shift_out = 1'b0; wdata = '0;
    #1 res_n = 1'b0;
    #1;
    chk("rst_early.empty", 32'(empty), 32'd1);
    chk("rst_early.full",  32'(full),  32'd0);
    chk("rst_early.rdata", 32'(rdata), 32'd0);
    #49;
    chk("rst_mid.rdata", 32'(rdata), 32'd0);
    #49;
    chk("rst_late.empty", 32'(empty), 32'd1);
    chk("rst_late.full",  32'(full),  32'd0);
    chk("rst_late.rdata", 32'(rdata), 32'd0);
    #1 res_n = 1'b1;

    // Fill, then an overflow push that must be dropped.
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, WIDTH'(8'h11 * i), "fill");
      chk("fill.head", 32'(rdata), 32'h11);
    end
    chk("fill.full", 32'(full), 32'd1);
    step(1'b1, 1'b0, 8'h66, "overflow");

    // Drain in order, then an underflow pop.
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) chk("drain.pre", 32'(rdata), 32'(8'h11 * i));
      step(1'b0, 1'b1, 8'h00, "drain");
    end
    chk("drain.empty", 32'(empty), 32'd1);
    step(1'b0, 1'b1, 8'h00, "underflow");
    chk("underflow.full", 32'(full), 32'd0);

    // Pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, WIDTH'($urandom), "wrap.push3");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, "wrap.pop3");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WIDTH'(8'hA0 + i), "wrap.push5");
    for (int i = 0; i < 5; i++) begin
      chk("wrap.order", 32'(rdata), 32'(8'hA0 + i));
      step(1'b0, 1'b1, 8'h00, "wrap.pop5");
    end

    // Simultaneous push/pop when full and when empty.
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, WIDTH'(8'h11 * i), "sim.fill");
    step(1'b1, 1'b1, 8'h66, "sim.full");
    chk("sim.full.full",  32'(full),  32'd1);
    chk("sim.full.rdata", 32'(rdata), 32'h22);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, "sim.drain");
    chk("sim.drained.last", 32'(empty), 32'd1);
    step(1'b1, 1'b1, 8'h77, "sim.empty");
    chk("sim.empty.empty", 32'(empty), 32'd0);
    chk("sim.empty.rdata", 32'(rdata), 32'h77);

    // Mid-operation reset between edges.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, WIDTH'($urandom), "mid.push");
    res_n = 1'b0;
    #2;
    chk("mid.rst.empty", 32'(empty), 32'd1);
    chk("mid.rst.full",  32'(full),  32'd0);
    chk("mid.rst.rdata", 32'(rdata), 32'd0);
    res_n = 1'b1;
    q.delete();
    step(1'b1, 1'b0, 8'h99, "mid.after");
    chk("mid.after.rdata", 32'(rdata), 32'h99);

    // Randomized traffic in three bias phases (fill-heavy, balanced, drain-heavy).
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 150; i++) begin
        int pin, pout;
        pin  = (ph == 0) ? 75 : (ph == 1) ? 50 : 25;
        pout = 100 - pin;
        step(($urandom_range(0, 99) < pin), ($urandom_range(0, 99) < pout),
             WIDTH'($urandom), "rand");
      end
    end

    shift_in = 1'b0; shift_out = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
